msx_bus_initiator: RTL and testbench

Host-side MSX slot bus cycle generator: accepts single memory or I/O read/write requests over a valid/ready handshake and drives the cartridge-slot signals with Z80-compatible T-state sequencing, including WAIT_n stretching.
- Use: drives any cartridge-facing bus port (MEGAROM, FM, NEXTOR, RAM, PSG, V9990) from an internal master.
- Targets: self-test logic, boot-time probing of expansion slots, and the block-level benches for the cartridges.

---
 rtl/bus_initiator_pkg.sv | 23 ++
 rtl/bus_tstate_timer.sv | 28 ++
 rtl/msx_bus_initiator.sv | 186 ++++++++++++++++++
 tb/tb_msx_bus_initiator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_initiator_pkg.sv
// Shared state, request and synchroniser definitions for the MSX slot bus initiator.
package bus_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3,
    DONE
  } state_e;

  typedef struct packed {
    logic        io;
    logic        write;
    logic        sltsl;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  localparam int WAIT_SYNC_STAGES = 2;

endpackage

// File: rtl/bus_tstate_timer.sv
// T-state timer: counts CLK cycles within one Z80 T-state and flags its last clock.
module bus_tstate_timer #(
  parameter int unsigned T_CYCLES = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic lastClk_o
);

  localparam logic [5:0] LastCnt = 6'(T_CYCLES - 1);

  logic [5:0] cnt_q;

  assign lastClk_o = (cnt_q == LastCnt);

  // Restarting on accept aligns the first T1 clock with count zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (restart_i || (cnt_q == LastCnt)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 6'd1;
    end
  end

endmodule

// File: rtl/msx_bus_initiator.sv
// MSX cartridge-slot bus cycle generator with Z80 T-state sequencing and WAIT_n stretching.
module msx_bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int unsigned T_CYCLES   = 6,
  parameter int unsigned WAIT_LIMIT = 1024
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_IO,
  input  logic        REQ_WRITE,
  input  logic        REQ_SLTSL,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        RESP_VALID,
  output logic [7:0]  RESP_RDATA,
  output logic        RESP_ERR,
  output logic [15:0] ADDR,
  output logic [7:0]  DOUT,
  output logic        DOUT_OE,
  input  logic [7:0]  DIN,
  output logic        SLTSL_n,
  output logic        MERQ_n,
  output logic        IORQ_n,
  output logic        RD_n,
  output logic        WR_n,
  input  logic        WAIT_n
);

  localparam logic [15:0] WaitLimit = 16'(WAIT_LIMIT);

  state_e                      state_q;
  req_t                        req_q;
  logic [15:0]                 waitCnt_q;
  logic [15:0]                 waitCnt_d;
  logic                        err_q;
  logic [WAIT_SYNC_STAGES-1:0] waitSync_q;
  logic                        ready_q;
  logic                        respValid_q;
  logic                        respErr_q;
  logic [7:0]                  rdata_q;
  logic                        doutOe_q;
  logic                        sltsl_q;
  logic                        merq_q;
  logic                        iorq_q;
  logic                        rd_q;
  logic                        wr_q;
  logic                        lastClk;
  logic                        accept;
  logic                        waitReq;
  logic                        stretch_d;
  logic                        timeout_d;
  req_t                        reqIn;

  assign accept  = ready_q && REQ_VALID;
  assign waitReq = !waitSync_q[WAIT_SYNC_STAGES-1];
  assign reqIn   = '{io: REQ_IO, write: REQ_WRITE, sltsl: REQ_SLTSL,
                     addr: REQ_ADDR, wdata: REQ_WDATA};

  bus_tstate_timer #(
    .T_CYCLES(T_CYCLES)
  ) u_timer (
    .clk_i    (CLK),
    .rst_ni   (RESET_n),
    .restart_i(accept),
    .lastClk_o(lastClk)
  );

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      waitSync_q <= '1;
    end else begin
      waitSync_q <= {waitSync_q[WAIT_SYNC_STAGES-2:0], WAIT_n};
    end
  end

  // A requested wait beyond the limit turns into an erroring T3 instead of another TW.
  always_comb begin
    waitCnt_d = waitCnt_q;
    stretch_d = 1'b0;
    timeout_d = 1'b0;
    if (waitReq) begin
      if (waitCnt_q >= WaitLimit) begin
        timeout_d = 1'b1;
      end else begin
        stretch_d = 1'b1;
        waitCnt_d = waitCnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      waitCnt_q   <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      rdata_q     <= 8'hFF;
      doutOe_q    <= 1'b0;
      sltsl_q     <= 1'b1;
      merq_q      <= 1'b1;
      iorq_q      <= 1'b1;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
    end else begin
      respValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= T1;
            req_q     <= reqIn;
            ready_q   <= 1'b0;
            doutOe_q  <= REQ_WRITE;
            waitCnt_q <= '0;
            err_q     <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        T1: begin
          if (lastClk) begin
            state_q <= T2;
            merq_q  <= req_q.io;
            iorq_q  <= !req_q.io;
            rd_q    <= req_q.write;
            wr_q    <= !req_q.write;
            sltsl_q <= req_q.io || !req_q.sltsl;
          end
        end
        T2, TW: begin
          if (lastClk) begin
            if ((state_q == T2) && req_q.io) begin
              state_q <= TW;
            end else if (stretch_d) begin
              state_q   <= TW;
              waitCnt_q <= waitCnt_d;
            end else begin
              state_q <= T3;
              err_q   <= timeout_d;
            end
          end
        end
        T3: begin
          if (lastClk) begin
            state_q     <= DONE;
            respValid_q <= 1'b1;
            respErr_q   <= err_q;
            doutOe_q    <= 1'b0;
            sltsl_q     <= 1'b1;
            merq_q      <= 1'b1;
            iorq_q      <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            if (!req_q.write) begin
              rdata_q <= err_q ? 8'hFF : DIN;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ_READY  = ready_q;
  assign RESP_VALID = respValid_q;
  assign RESP_RDATA = rdata_q;
  assign RESP_ERR   = respErr_q;
  assign ADDR       = req_q.addr;
  assign DOUT       = req_q.wdata;
  assign DOUT_OE    = doutOe_q;
  assign SLTSL_n    = sltsl_q;
  assign MERQ_n     = merq_q;
  assign IORQ_n     = iorq_q;
  assign RD_n       = rd_q;
  assign WR_n       = wr_q;

endmodule

// File: tb/tb_msx_bus_initiator.sv
// Bench for msx_bus_initiator: directed slot-bus scenarios plus random requests
// compared against a T-state level timing model.
module tb_msx_bus_initiator;

  localparam int TC = 6;
  localparam int WL = 4;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_IO = 1'b0;
  logic        REQ_WRITE = 1'b0;
  logic        REQ_SLTSL = 1'b0;
  logic [15:0] REQ_ADDR = '0;
  logic [7:0]  REQ_WDATA = '0;
  logic        RESP_VALID;
  logic [7:0]  RESP_RDATA;
  logic        RESP_ERR;
  logic [15:0] ADDR;
  logic [7:0]  DOUT;
  logic        DOUT_OE;
  logic [7:0]  DIN = '0;
  logic        SLTSL_n;
  logic        MERQ_n;
  logic        IORQ_n;
  logic        RD_n;
  logic        WR_n;
  logic        WAIT_n = 1'b1;
  logic [4:0]  strobes;

  int checks = 0;
  int errors = 0;

  assign strobes = {SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n};

  always #5 CLK = ~CLK;

  msx_bus_initiator #(
    .T_CYCLES  (TC),
    .WAIT_LIMIT(WL)
  ) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_IO    (REQ_IO),
    .REQ_WRITE (REQ_WRITE),
    .REQ_SLTSL (REQ_SLTSL),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RESP_VALID(RESP_VALID),
    .RESP_RDATA(RESP_RDATA),
    .RESP_ERR  (RESP_ERR),
    .ADDR      (ADDR),
    .DOUT      (DOUT),
    .DOUT_OE   (DOUT_OE),
    .DIN       (DIN),
    .SLTSL_n   (SLTSL_n),
    .MERQ_n    (MERQ_n),
    .IORQ_n    (IORQ_n),
    .RD_n      (RD_n),
    .WR_n      (WR_n),
    .WAIT_n    (WAIT_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit lowAt(input int c, input int ws, input int wl);
    return (c >= ws) && (c < ws + wl);
  endfunction

  // Cycle index 0 is the first T1 clock; WAIT_n is low for cycles [ws, ws+wl).
  task automatic applyStimulus(input logic io, input logic wr, input logic sl,
                               input logic [15:0] addr, input logic [7:0] wdata,
                               input logic [7:0] din, input int ws, input int wl,
                               input bit keepValid, input int expReadyWait);
    int w, dec, expResp, strobeLen, e, respEdge, readyWait;
    int rwLow, wrongLow, spaceLow, sltslLow, oeHigh, firstLow, t1Bad, busBad, relBad;
    bit expErr;
    logic [7:0] rdata;
    logic err;

    // Sample points fall on the last clock of T2/TW; the synchroniser sees WAIT_n two clocks late.
    w = 0;
    expErr = 1'b0;
    dec = (io ? 3 : 2) * TC;
    while (lowAt(dec - 3, ws, wl)) begin
      if (w == WL) begin
        expErr = 1'b1;
        break;
      end
      w++;
      dec += TC;
    end
    expResp = ((io ? 4 : 3) + w) * TC;
    strobeLen = expResp - TC;

    REQ_IO = io;
    REQ_WRITE = wr;
    REQ_SLTSL = sl;
    REQ_ADDR = addr;
    REQ_WDATA = wdata;
    REQ_VALID = 1'b1;
    DIN = din;
    readyWait = 0;
    while (!REQ_READY && readyWait < 20) begin
      @(posedge CLK); #1;
      readyWait++;
    end
    if (expReadyWait >= 0) checkOutput("readyWait", readyWait, expReadyWait);
    @(posedge CLK); #1;
    if (!keepValid) REQ_VALID = 1'b0;

    rwLow = 0; wrongLow = 0; spaceLow = 0; sltslLow = 0; oeHigh = 0;
    firstLow = -1; t1Bad = 0; busBad = 0; relBad = 0;
    respEdge = -1; rdata = 8'h00; err = 1'b0;
    for (e = 0; e < 400; e++) begin
      WAIT_n = lowAt(e, ws, wl) ? 1'b0 : 1'b1;
      if (ADDR !== addr || (wr && DOUT !== wdata)) busBad++;
      if (RESP_VALID) begin
        respEdge = e;
        rdata = RESP_RDATA;
        err = RESP_ERR;
        if (strobes !== 5'h1F || DOUT_OE !== 1'b0) relBad++;
        break;
      end
      if (e < TC && strobes !== 5'h1F) t1Bad++;
      rwLow += wr ? int'(!WR_n) : int'(!RD_n);
      wrongLow += wr ? int'(!RD_n) : int'(!WR_n);
      spaceLow += io ? int'(!IORQ_n) : int'(!MERQ_n);
      wrongLow += io ? int'(!MERQ_n) : int'(!IORQ_n);
      sltslLow += int'(!SLTSL_n);
      oeHigh += int'(DOUT_OE);
      if (firstLow < 0 && (!RD_n || !WR_n)) firstLow = e;
      @(posedge CLK); #1;
    end
    WAIT_n = 1'b1;

    checkOutput("respLatency", respEdge, expResp);
    checkOutput("respErr", err, expErr);
    if (!wr) checkOutput("respRdata", rdata, expErr ? 8'hFF : din);
    checkOutput("rwStrobeLow", rwLow, strobeLen);
    checkOutput("spaceStrobeLow", spaceLow, strobeLen);
    checkOutput("wrongStrobeLow", wrongLow, 0);
    checkOutput("sltslLow", sltslLow, (!io && sl) ? strobeLen : 0);
    checkOutput("doutOeHigh", oeHigh, wr ? expResp : 0);
    checkOutput("strobeStart", firstLow, TC);
    checkOutput("t1Strobes", t1Bad, 0);
    checkOutput("busHold", busBad, 0);
    checkOutput("strobeRelease", relBad, 0);
  endtask

  task automatic applyResetMidTw();
    int seen;
    REQ_IO = 1'b0;
    REQ_WRITE = 1'b1;
    REQ_SLTSL = 1'b0;
    REQ_ADDR = 16'h8123;
    REQ_WDATA = 8'h5C;
    REQ_VALID = 1'b1;
    for (int i = 0; i < 20 && !REQ_READY; i++) begin
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    for (int e = 0; e < 20; e++) begin
      WAIT_n = lowAt(e, TC, 40) ? 1'b0 : 1'b1;
      @(posedge CLK); #1;
    end
    checkOutput("preResetStrobes", strobes, 5'b10110);
    checkOutput("preResetOe", DOUT_OE, 1'b1);
    #2 RESET_n = 1'b0;
    #1;
    checkOutput("resetStrobes", strobes, 5'h1F);
    checkOutput("resetOe", DOUT_OE, 1'b0);
    checkOutput("resetAddr", ADDR, 16'h0000);
    checkOutput("resetDout", DOUT, 8'h00);
    checkOutput("resetRdata", RESP_RDATA, 8'hFF);
    checkOutput("resetReady", REQ_READY, 1'b0);
    WAIT_n = 1'b1;
    seen = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      seen += int'(RESP_VALID);
    end
    #2 RESET_n = 1'b1;
    #1;
    checkOutput("readyAtRelease", REQ_READY, 1'b0);
    @(posedge CLK); #1;
    checkOutput("readyAfterRelease", REQ_READY, 1'b1);
    repeat (40) begin
      @(posedge CLK); #1;
      seen += int'(RESP_VALID);
    end
    checkOutput("noRespAfterReset", seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic        rIo, rWr, rSl;
    logic [15:0] rAddr;
    logic [7:0]  rWd, rDin;
    int          rWs, rWl;

    #2 RESET_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rstStrobes", strobes, 5'h1F);
    checkOutput("rstOe", DOUT_OE, 1'b0);
    checkOutput("rstAddr", ADDR, 16'h0000);
    checkOutput("rstDout", DOUT, 8'h00);
    checkOutput("rstReady", REQ_READY, 1'b0);
    checkOutput("rstRespValid", RESP_VALID, 1'b0);
    checkOutput("rstRdata", RESP_RDATA, 8'hFF);
    checkOutput("rstErr", RESP_ERR, 1'b0);
    #2 RESET_n = 1'b1;
    #1;
    checkOutput("rstReadyHeld", REQ_READY, 1'b0);
    @(posedge CLK); #1;
    checkOutput("rstReadyRise", REQ_READY, 1'b1);

    $display("[TB] memory read, no wait");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 8'hA5, 0, 0, 1'b0, -1);
    $display("[TB] I/O write");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h00A0, 8'h07, 8'h00, 0, 0, 1'b0, -1);
    $display("[TB] wait stretch");
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h3C, TC, 20, 1'b0, -1);
    $display("[TB] wait timeout");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h7FFE, 8'h00, 8'h99, TC, 1000, 1'b0, -1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hBEEF, 8'h00, 8'h42, 2 * TC, 1000, 1'b0, -1);
    $display("[TB] back-to-back writes");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hC000, 8'h11, 8'h00, 0, 0, 1'b1, -1);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0098, 8'h22, 8'h00, 0, 0, 1'b0, 1);
    $display("[TB] reset during TW");
    applyResetMidTw();

    $display("[TB] random requests");
    for (int i = 0; i < 14; i++) begin
      rIo = 1'($urandom);
      rWr = 1'($urandom);
      rSl = 1'($urandom);
      rAddr = 16'($urandom);
      rWd = 8'($urandom);
      rDin = 8'($urandom);
      rWs = TC + int'($urandom_range(0, 2 * TC));
      rWl = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 50));
      applyStimulus(rIo, rWr, rSl, rAddr, rWd, rDin, rWs, rWl, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
